// File: rtl/mms_pkg.sv
// Shared types and defaults for the instruction cache slice.
package mms_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissData,
    StFlush
  } icache_state_e;

  localparam int unsigned ICACHE_WAYS_DEF       = 2;
  localparam int unsigned ICACHE_SETS_DEF       = 64;
  localparam int unsigned ICACHE_LINE_WORDS_DEF = 4;

  typedef logic [31:0]                             insn_t;
  typedef insn_t [ICACHE_LINE_WORDS_DEF-1:0]       icache_line_t;

  // Width of an index selecting one of n items, never narrower than one bit.
  function automatic int unsigned icache_sel_wd(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag and data arrays with a registered line read and
// word-granular refill writes. Arrays are deliberately not reset.
module icache_way
  import mms_pkg::*;
#(
  parameter int unsigned SETS       = ICACHE_SETS_DEF,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS_DEF,
  parameter int unsigned TAG_WD     = 22,
  localparam int unsigned IDX_WD    = $clog2(SETS),
  localparam int unsigned WOFF_WD   = $clog2(LINE_WORDS)
) (
  input  logic                       clk,
  input  logic                       rd_en_i,
  input  logic [IDX_WD-1:0]          rd_idx_i,
  output logic [TAG_WD-1:0]          rd_tag_o,
  output logic [LINE_WORDS*32-1:0]   rd_line_o,
  input  logic                       wr_en_i,
  input  logic [IDX_WD-1:0]          wr_idx_i,
  input  logic [WOFF_WD-1:0]         wr_word_i,
  input  logic [31:0]                wr_data_i,
  input  logic                       tag_we_i,
  input  logic [TAG_WD-1:0]          tag_i
);

  logic [TAG_WD-1:0]        tag_mem  [SETS];
  logic [31:0]              data_mem [SETS][LINE_WORDS];
  logic [TAG_WD-1:0]        rd_tag_q;
  logic [LINE_WORDS*32-1:0] rd_line_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_mem[wr_idx_i][wr_word_i] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_mem[wr_idx_i] <= tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_tag_q <= tag_mem[rd_idx_i];
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        rd_line_q[32*k +: 32] <= data_mem[rd_idx_i][k];
      end
    end
  end

  assign rd_tag_o  = rd_tag_q;
  assign rd_line_o = rd_line_q;

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with whole-line responses and
// beat-wise refill. Define ICACHE_PERF_EN to add hit/miss counter ports.
module icache_nway
  import mms_pkg::*;
#(
  parameter int unsigned WAYS       = ICACHE_WAYS_DEF,
  parameter int unsigned SETS       = ICACHE_SETS_DEF,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS_DEF,
  parameter int unsigned ADDR_WD    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_WD-1:0]         req_addr_i,
  output logic                       rsp_valid_o,
  output logic [LINE_WORDS*32-1:0]   rsp_data_o,
  input  logic                       flush_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [ADDR_WD-1:0]         mem_req_addr_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [31:0]                mem_rsp_data_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                hit_cnt_o,
  output logic [31:0]                miss_cnt_o
`endif
);

  localparam int unsigned IDX_WD  = $clog2(SETS);
  localparam int unsigned WOFF_WD = $clog2(LINE_WORDS);
  localparam int unsigned OFF_WD  = WOFF_WD + 2;
  localparam int unsigned TAG_WD  = ADDR_WD - OFF_WD - IDX_WD;
  localparam int unsigned WAY_WD  = icache_sel_wd(WAYS);
  localparam int unsigned LINE_WD = LINE_WORDS * 32;
  localparam int unsigned LA_WD   = ADDR_WD - OFF_WD;

  icache_state_e            state_q;
  logic [LA_WD-1:0]         line_addr_q;
  logic [WAYS-1:0]          valid_q [SETS];
  logic [WAY_WD-1:0]        victim_q;
  logic [WOFF_WD-1:0]       beat_q;
  logic [LINE_WD-1:0]       line_q;
  logic                     fill_done_q;
  logic                     flush_pend_q;
  logic                     mem_req_valid_q;
  logic [ADDR_WD-1:0]       mem_req_addr_q;

  logic [IDX_WD-1:0]        req_idx;
  logic [IDX_WD-1:0]        idx_cur;
  logic [TAG_WD-1:0]        tag_cur;
  logic                     accept;
  logic                     beat_we;
  logic                     last_beat;
  logic [TAG_WD-1:0]        way_tag  [WAYS];
  logic [LINE_WD-1:0]       way_line [WAYS];
  logic [WAYS-1:0]          hit_vec;
  logic                     hit;
  logic                     lookup_hit;
  logic [LINE_WD-1:0]       hit_line;
  logic [WAY_WD-1:0]        rr_cur;
  logic [WAY_WD-1:0]        victim_d;
  logic                     unused_addr;

  assign req_idx     = req_addr_i[OFF_WD +: IDX_WD];
  assign unused_addr = ^req_addr_i[OFF_WD-1:0];
  assign idx_cur     = line_addr_q[IDX_WD-1:0];
  assign tag_cur     = line_addr_q[IDX_WD +: TAG_WD];

  // rst_n gates ready directly so it reads low for the whole reset pulse.
  assign req_ready_o = rst_n && (state_q == StIdle) && !flush_pend_q && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign beat_we     = (state_q == StMissData) && mem_rsp_valid_i;
  assign last_beat   = beat_we && (beat_q == WOFF_WD'(LINE_WORDS - 1));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_WD     (TAG_WD)
    ) u_way (
      .clk        (clk),
      .rd_en_i    (accept),
      .rd_idx_i   (req_idx),
      .rd_tag_o   (way_tag[w]),
      .rd_line_o  (way_line[w]),
      .wr_en_i    (beat_we && (victim_q == WAY_WD'(w))),
      .wr_idx_i   (idx_cur),
      .wr_word_i  (beat_q),
      .wr_data_i  (mem_rsp_data_i),
      .tag_we_i   (last_beat && (victim_q == WAY_WD'(w))),
      .tag_i      (tag_cur)
    );
  end

  always_comb begin
    hit_vec  = '0;
    hit_line = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx_cur][w] && (way_tag[w] == tag_cur);
      if (hit_vec[w]) begin
        hit_line = way_line[w];
      end
    end
  end

  assign hit        = |hit_vec;
  assign lookup_hit = (state_q == StLookup) && hit;

  // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    logic found;
    found    = 1'b0;
    victim_d = rr_cur;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[idx_cur][w]) begin
        victim_d = WAY_WD'(w);
        found    = 1'b1;
      end
    end
  end

  if (WAYS > 1) begin : g_rr
    logic [WAY_WD-1:0] rr_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (state_q == StFlush) begin
        for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (last_beat) begin
        rr_q[idx_cur] <= (rr_q[idx_cur] == WAY_WD'(WAYS - 1)) ? '0
                                                              : rr_q[idx_cur] + WAY_WD'(1);
      end
    end

    assign rr_cur = rr_q[idx_cur];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      line_addr_q     <= '0;
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
      victim_q        <= '0;
      beat_q          <= '0;
      line_q          <= '0;
      fill_done_q     <= 1'b0;
      flush_pend_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      fill_done_q <= 1'b0;
      if (flush_i && (state_q != StIdle)) begin
        flush_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (flush_i || flush_pend_q) begin
            state_q <= StFlush;
          end else if (accept) begin
            line_addr_q <= req_addr_i[ADDR_WD-1:OFF_WD];
            state_q     <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            state_q <= StIdle;
          end else begin
            victim_q        <= victim_d;
            beat_q          <= '0;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {line_addr_q, {OFF_WD{1'b0}}};
            state_q         <= StMissReq;
          end
        end
        StMissReq: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= StMissData;
          end
        end
        StMissData: begin
          if (mem_rsp_valid_i) begin
            line_q[32*int'(beat_q) +: 32] <= mem_rsp_data_i;
            beat_q                        <= beat_q + WOFF_WD'(1);
            if (last_beat) begin
              valid_q[idx_cur][victim_q] <= 1'b1;
              fill_done_q                <= 1'b1;
              state_q                    <= StIdle;
            end
          end
        end
        StFlush: begin
          for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
          flush_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o     = lookup_hit || fill_done_q;
  assign rsp_data_o      = fill_done_q ? line_q : (lookup_hit ? hit_line : '0);
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
